// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a ripple ALU, waits SETTLE_CYCLES edges, captures result/flags, derives CR0.
// Optional ALU_XER_STICKY_EN: sticky summary-overflow bit feeding rsp_cr0[0], clearable with so_clr.
module alu_cmd_issuer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [1:0]  ALUOP_AND     = 2'b00,
  parameter logic [1:0]  ALUOP_OR      = 2'b01,
  parameter logic [1:0]  ALUOP_SUB     = 2'b10,
  parameter logic [1:0]  ALUOP_SLT     = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_negative,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_cr0,
  output logic        rsp_ca,
  output logic        rsp_ov,
  output logic        rsp_err,
  input  logic        so_clr
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [3:0]  cr0_q, cr0_d;
  logic        ca_q, ca_d, ov_q, ov_d, err_q, err_d;
  logic        so_q, so_d;

  logic        cmd_legal;
  logic [1:0]  cmd_op;
  logic        is_sub, new_ov, new_ca, lt, eq, so_new;

  always_comb begin
    cmd_legal = 1'b1;
    cmd_op    = ALUOP_AND;
    case (req_cmd)
      3'b000:         cmd_op = ALUOP_AND;
      3'b001:         cmd_op = ALUOP_OR;
      3'b010, 3'b011: cmd_op = ALUOP_SUB;
      3'b100:         cmd_op = ALUOP_SLT;
      default:        cmd_legal = 1'b0;
    endcase
  end

  // SUB/CMP compare signed via N^V; logical ops and SLT look at the result sign.
  assign is_sub = (alu_op_q == ALUOP_SUB);
  assign new_ov = is_sub & alu_overflow;
  assign new_ca = is_sub & alu_carryout;
  assign lt     = is_sub ? (alu_negative ^ alu_overflow) : alu_result[31];
  assign eq     = alu_zero;

`ifdef ALU_XER_STICKY_EN
  assign so_new = ((so_clr ? 1'b0 : so_q) | new_ov);
`else
  logic unused_so_clr;
  assign unused_so_clr = so_clr;
  assign so_new = new_ov;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    cr0_d    = cr0_q;
    ca_d     = ca_q;
    ov_d     = ov_q;
    err_d    = err_q;
    so_d     = so_q;
    case (state_q)
      IDLE: begin
`ifdef ALU_XER_STICKY_EN
        if (so_clr) so_d = 1'b0;
`endif
        if (req_valid) begin
          if (cmd_legal) begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = cmd_op;
            cnt_d    = CW'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
          end else begin
            res_d   = '0;
            cr0_d   = '0;
            ca_d    = 1'b0;
            ov_d    = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          cr0_d   = {lt, ~lt & ~eq, eq, so_new};
          ca_d    = new_ca;
          ov_d    = new_ov;
          err_d   = 1'b0;
          state_d = RESP;
`ifdef ALU_XER_STICKY_EN
          so_d    = so_new;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALUOP_AND;
      res_q    <= '0;
      cr0_q    <= '0;
      ca_q     <= 1'b0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
      so_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      cr0_q    <= cr0_d;
      ca_q     <= ca_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
      so_q     <= so_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = res_q;
  assign rsp_cr0    = cr0_q;
  assign rsp_ca     = ca_q;
  assign rsp_ov     = ov_q;
  assign rsp_err    = err_q;

endmodule
